// File: rtl/pcihellocore_seg_scan_if.sv
// Signal bundle between the seg_digits PIO word and the multiplexed
// four-digit seven-segment display scanner.
interface pcihellocore_seg_scan_if;
  logic        enable;
  logic [31:0] seg_word;
  logic [7:0]  seg_out;
  logic [3:0]  dig_en_n;
  logic        frame_tick;

  modport master (
    output enable, seg_word,
    input  seg_out, dig_en_n, frame_tick
  );

  modport slave (
    input  enable, seg_word,
    output seg_out, dig_en_n, frame_tick
  );
endinterface

// File: rtl/pcihellocore_seg_scan.sv
// Time-multiplexed seven-segment scanner: blank gap before every digit,
// segment word re-latched only at frame boundaries so host writes never tear.
module pcihellocore_seg_scan #(
  parameter int DIGIT_CYCLES = 12500,
  parameter int BLANK_CYCLES = 500
) (
  input logic clk,
  input logic reset,
  pcihellocore_seg_scan_if.slave bus
);

  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [1:0]       idx, idx_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [31:0]      shadow, shadow_next;
  logic [7:0]       seg_next;
  logic [3:0]       dig_next;
  logic             tick_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= 2'd0;
      cnt             <= '0;
      shadow          <= 32'hFFFF_FFFF;
      bus.seg_out     <= 8'hFF;
      bus.dig_en_n    <= 4'hF;
      bus.frame_tick  <= 1'b0;
    end else begin
      state           <= state_next;
      idx             <= idx_next;
      cnt             <= cnt_next;
      shadow          <= shadow_next;
      bus.seg_out     <= seg_next;
      bus.dig_en_n    <= dig_next;
      bus.frame_tick  <= tick_next;
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they describe; nothing lights outside DRIVE.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    cnt_next    = cnt;
    shadow_next = shadow;
    tick_next   = 1'b0;
    seg_next    = 8'hFF;
    dig_next    = 4'hF;

    if (!bus.enable) begin
      state_next = IDLE;
      idx_next   = 2'd0;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          shadow_next = bus.seg_word;
          tick_next   = 1'b1;
          idx_next    = 2'd0;
          cnt_next    = '0;
          state_next  = BLANK;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt_next   = '0;
            state_next = DRIVE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == DIGIT_LAST) begin
            cnt_next   = '0;
            state_next = BLANK;
            if (idx == 2'd3) begin
              idx_next    = 2'd0;
              shadow_next = bus.seg_word;
              tick_next   = 1'b1;
            end else begin
              idx_next = idx + 2'd1;
            end
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = 2'd0;
          cnt_next   = '0;
        end
      endcase
    end

    if (state_next == DRIVE) begin
      dig_next = ~(4'b0001 << idx_next);
      seg_next = shadow_next[{idx_next, 3'b000} +: 8];
    end
  end

endmodule

// File: doc/pcihellocore_seg_scan.md
# pcihellocore_seg_scan

Time-multiplexed seven-segment scanner sitting directly downstream of the `seg_digits` PIO register in `pcihellocore`. It takes the 32-bit segment word (four active-low segment bytes, host-written over PCIe) and drives a 4-digit display that has shared segment lines and per-digit enables. Digits are driven one at a time, with a blanking gap between digits to suppress ghosting. The segment word is re-sampled only at frame boundaries, so host writes never tear mid-frame.

## Interface
- `DIGIT_CYCLES`, 12500, clock cycles each digit is driven. At 50 MHz this is 250 µs. Minimum 1.
- `BLANK_CYCLES`, 500, clock cycles all digits are off before each digit is driven. Minimum 1.

- `clk`  in  1  system clock. Rising edge only.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  scan enable. Low forces the display dark.
- `seg_word`  in  32  segment codes from `seg_digits.out_port`.
  - Byte *i* (bits 8i+7..8i) is for digit *i*.
  - Bit 7 of each byte is the decimal point; bits 6..0 are segments g..a.
  - All active-low.
- `seg_out`  out  8  shared segment lines, active-low.
- `dig_en_n`  out  4  digit enables, active-low, one-hot-low while driving.
- `frame_tick`  out  1  one-cycle pulse on the edge where `seg_word` is latched.

## Operation
- Internal state:
  - FSM states: IDLE, BLANK, DRIVE.
  - 2-bit digit index `idx`.
  - cycle counter `cnt`, sized to clog2(max(DIGIT_CYCLES, BLANK_CYCLES)).
  - 32-bit shadow register `shadow`.
- Reset values:
  - state = IDLE, `idx` = 0, `cnt` = 0.
  - `shadow` = 32'hFFFF_FFFF.
  - `seg_out` = 8'hFF, `dig_en_n` = 4'hF, `frame_tick` = 0.
- IDLE:
  - Outputs dark (`seg_out` = FF, `dig_en_n` = F).
  - On an edge with `enable` = 1: `shadow` <= `seg_word`, `frame_tick` <= 1, `idx` <= 0, `cnt` <= 0, state <= BLANK.
- BLANK:
  - Outputs dark. Stays BLANK_CYCLES cycles (`cnt` runs 0..BLANK_CYCLES-1).
  - Then `cnt` <= 0 and state <= DRIVE.
- DRIVE:
  - `dig_en_n` = ~(1 << `idx`); `seg_out` = `shadow` byte `idx`.
  - Stays DIGIT_CYCLES cycles.
  - On the last cycle, if `idx` < 3: `idx` <= `idx` + 1, state <= BLANK.
  - On the last cycle, if `idx` = 3 (frame boundary): `idx` <= 0, `shadow` <= `seg_word`, `frame_tick` <= 1, state <= BLANK.
- `enable` low in any state: next edge goes to IDLE.
  - Outputs dark; `cnt` and `idx` cleared; `shadow` holds.
  - Re-enable restarts at digit 0 with a fresh latch.
- Changes on `seg_word` between frame boundaries have no effect on the outputs until the next latch.
- At most one digit enable is ever low. `seg_out` is FF whenever `dig_en_n` = F.

## Timing
- All outputs are registered and change only on `clk` rising edges, or asynchronously on `reset`.
- Latency: first DRIVE of digit 0 begins BLANK_CYCLES+1 edges after the first edge sampling `enable` = 1 in IDLE.
- Frame period: 4 × (BLANK_CYCLES + DIGIT_CYCLES) cycles. `frame_tick` is exactly one cycle wide, once per frame.
- Transitions between digits always pass through BLANK. There is no cycle where two digits are enabled, or where a digit is enabled with the previous digit's segments.
- `reset` asserted mid-frame: outputs go dark immediately, without waiting for a clock. After release, the first edge behaves as IDLE.
- `seg_word` is a host-written register in the same clock domain, so no synchroniser is needed.

## Test plan
All scenarios use DIGIT_CYCLES = 4 and BLANK_CYCLES = 2 (frame = 24 cycles).

1. **Reset and start-up.**
   - Stimulus: assert `reset` with `enable` = 1, then release. `seg_word` = 32'h40_79_24_30.
   - Response while in reset: `seg_out` = FF, `dig_en_n` = F.
   - First edge after release: `frame_tick` = 1.
   - Edges 3–6: `dig_en_n` = 4'b1110, `seg_out` = 8'h30.
   - Then 2 dark cycles, then digit 1 (`dig_en_n` = 1101) with `seg_out` = 24.
   - Then digit 2 (1011) = 79, then digit 3 (0111) = 40.
2. **Tear-free update.**
   - Stimulus: change `seg_word` to 32'hFFFF_FF00 while digit 1 is driving.
   - Response: digits 1–3 still show the old bytes for this frame.
   - The next frame, after `frame_tick`, shows digit 0 = 00 and digits 1–3 = FF.
3. **Anti-ghost invariant.**
   - Stimulus: run 10 frames with random `seg_word` changes.
   - Response: `dig_en_n` is never other than F or one-hot-low.
   - `seg_out` = FF whenever `dig_en_n` = F.
   - `frame_tick` is asserted exactly every 24 cycles.
4. **Enable drop mid-frame.**
   - Stimulus: deassert `enable` during digit 2 DRIVE, hold 5 cycles, then reassert.
   - Response: outputs go dark on the next edge.
   - On re-enable, `frame_tick` pulses and digit 0 is driven after 2 blank cycles.
5. **Async reset mid-DRIVE.**
   - Stimulus: pulse `reset` between clock edges during digit 3.
   - Response: `dig_en_n` = F and `seg_out` = FF immediately, with no clock edge needed.
   - Restart as in scenario 1.
6. **Default parameters.**
   - Stimulus: one frame at default parameters.
   - Response: `frame_tick` period = 52000 cycles; each digit is low for 12500 cycles.
